// File: rtl/risc_control_unit_pkg.sv
// Shared ISA constants and run-control state type for the RISC control unit.
package risc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_ALU     = 5'b00000;
    localparam logic [4:0] OP_LHI     = 5'b00001;
    localparam logic [4:0] OP_LLI     = 5'b00010;
    localparam logic [4:0] OP_LDR_IMM = 5'b00011;
    localparam logic [4:0] OP_LDR_REG = 5'b00100;
    localparam logic [4:0] OP_STR_IMM = 5'b00101;
    localparam logic [4:0] OP_STR_REG = 5'b00110;
    localparam logic [4:0] OP_ADDI    = 5'b00111;
    localparam logic [4:0] OP_SUBI    = 5'b01000;
    localparam logic [4:0] OP_CMP     = 5'b01001;
    localparam logic [4:0] OP_JMP     = 5'b10000;
    localparam logic [4:0] OP_JAL     = 5'b10001;
    localparam logic [4:0] OP_JR      = 5'b10010;
    localparam logic [4:0] OP_BCOND   = 5'b11000;
    localparam logic [4:0] OP_OUT     = 5'b11100;
    localparam logic [4:0] OP_HLT     = 5'b11111;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_ADC = 2'b01;
    localparam logic [1:0] FN_SUB = 2'b10;
    localparam logic [1:0] FN_SBB = 2'b11;

    localparam logic [2:0] CC_EQ = 3'b000;
    localparam logic [2:0] CC_NE = 3'b001;
    localparam logic [2:0] CC_CS = 3'b010;
    localparam logic [2:0] CC_CC = 3'b011;
    localparam logic [2:0] CC_MI = 3'b100;
    localparam logic [2:0] CC_PL = 3'b101;
    localparam logic [2:0] CC_VS = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Only ALU-class ops update the status register.
    function automatic logic is_flag_op(input logic [4:0] op);
        return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/risc_control_unit_if.sv
// Datapath-facing bundle: instruction and ALU flags in, datapath controls out.
interface risc_control_unit_if;
    logic [15:0] mem_instr_out;
    logic        Pre_C, Pre_V, Pre_Z, Pre_N;
    logic        Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH;
    logic        flag_label_PC, flag_Rm_PC, flag_Rd_PC, data_write_en;
    logic        flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, RF_write_en;
    logic        LHI, LLI, flag_OutR;

    modport master (
        input  mem_instr_out, Pre_C, Pre_V, Pre_Z, Pre_N,
        output Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH,
               flag_label_PC, flag_Rm_PC, flag_Rd_PC, data_write_en,
               flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, RF_write_en,
               LHI, LLI, flag_OutR
    );

    modport slave (
        output mem_instr_out, Pre_C, Pre_V, Pre_Z, Pre_N,
        input  Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH,
               flag_label_PC, flag_Rm_PC, flag_Rd_PC, data_write_en,
               flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, RF_write_en,
               LHI, LLI, flag_OutR
    );
endinterface

// File: rtl/risc_control_unit_cond_eval.sv
// Branch condition evaluation against the registered NZCV flags.
module risc_cond_eval
    import risc_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] nzcv,
    output logic       take
);
    always_comb begin
        take = 1'b0;
        case (cond)
            CC_EQ: take =  nzcv[NZCV_Z];
            CC_NE: take = !nzcv[NZCV_Z];
            CC_CS: take =  nzcv[NZCV_C];
            CC_CC: take = !nzcv[NZCV_C];
            CC_MI: take =  nzcv[NZCV_N];
            CC_PL: take = !nzcv[NZCV_N];
            CC_VS: take =  nzcv[NZCV_V];
            CC_AL: take = 1'b1;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/risc_control_unit.sv
// Instruction decode, NZCV register and LOAD/CLEAR/RUN/HALT run control.
// Define RISC_CTRL_ILLEGAL_TRAP_EN to halt on unused opcodes instead of NOP.
module risc_control_unit
    import risc_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       start,
    risc_control_unit_if.master        dp,
    output logic                       test_normal,
    output logic                       flag_HLT,
    output logic                       clr,
    output logic [3:0]                 nzcv,
    output logic                       halted
);
    // state | meaning
    // LOAD  | external memory owns the ports, wait for start
    // CLEAR | one-cycle datapath clear, NZCV zeroed
    // RUN   | decode and execute, PC advances
    // HALT  | stopped after HLT (or trapped opcode), wait for start

    state_t     state, state_nxt;
    logic [4:0] op;
    logic       run, take, illegal;
    logic       unused_instr_bits;

    assign op  = dp.mem_instr_out[15:11];
    assign run = (state == ST_RUN);
    assign unused_instr_bits = ^dp.mem_instr_out[7:2];

    risc_cond_eval u_cond (
        .cond (dp.mem_instr_out[10:8]),
        .nzcv (nzcv),
        .take (take)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_LOAD;
            nzcv  <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR)
                nzcv <= 4'b0000;
            else if (run && is_flag_op(op))
                nzcv <= {dp.Pre_N, dp.Pre_Z, dp.Pre_C, dp.Pre_V};
        end
    end

    always_comb begin
        state_nxt   = state;
        test_normal = 1'b0;
        flag_HLT    = 1'b0;
        clr         = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_LOAD: begin
                test_normal = 1'b1;
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr       = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                flag_HLT = 1'b1;
                if (op == OP_HLT || illegal) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                test_normal = 1'b1;
                halted      = 1'b1;
                if (start) state_nxt = ST_CLEAR;
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        dp.Src_Read_B    = 1'b0;
        dp.Src_ALU_B     = 1'b0;
        dp.ADC           = 1'b0;
        dp.SUB           = 1'b0;
        dp.SBB           = 1'b0;
        dp.JMP           = 1'b0;
        dp.BRANCH        = 1'b0;
        dp.flag_label_PC = 1'b0;
        dp.flag_Rm_PC    = 1'b0;
        dp.flag_Rd_PC    = 1'b0;
        dp.data_write_en = 1'b0;
        dp.flag_mem_RF   = 1'b0;
        dp.flag_ALU_RF   = 1'b0;
        dp.flag_Rm_RF    = 1'b0;
        dp.flag_PC_RF    = 1'b0;
        dp.RF_write_en   = 1'b0;
        dp.LHI           = 1'b0;
        dp.LLI           = 1'b0;
        dp.flag_OutR     = 1'b0;
        illegal          = 1'b0;
        if (run) begin
            case (op)
                OP_ALU: begin
                    dp.flag_ALU_RF = 1'b1;
                    dp.RF_write_en = 1'b1;
                    dp.ADC = (dp.mem_instr_out[1:0] == FN_ADC);
                    dp.SUB = (dp.mem_instr_out[1:0] == FN_SUB);
                    dp.SBB = (dp.mem_instr_out[1:0] == FN_SBB);
                end
                OP_LHI: begin
                    dp.LHI = 1'b1; dp.Src_Read_B = 1'b1; dp.RF_write_en = 1'b1;
                end
                OP_LLI: begin
                    dp.LLI = 1'b1; dp.RF_write_en = 1'b1;
                end
                OP_LDR_IMM: begin
                    dp.Src_ALU_B = 1'b1; dp.flag_mem_RF = 1'b1; dp.RF_write_en = 1'b1;
                end
                OP_LDR_REG: begin
                    dp.flag_mem_RF = 1'b1; dp.RF_write_en = 1'b1;
                end
                OP_STR_IMM: begin
                    dp.Src_ALU_B = 1'b1; dp.Src_Read_B = 1'b1; dp.data_write_en = 1'b1;
                end
                OP_STR_REG: begin
                    dp.Src_Read_B = 1'b1; dp.data_write_en = 1'b1;
                end
                OP_ADDI, OP_SUBI: begin
                    dp.Src_ALU_B   = 1'b1;
                    dp.flag_ALU_RF = 1'b1;
                    dp.RF_write_en = 1'b1;
                    dp.SUB         = (op == OP_SUBI);
                end
                OP_CMP: dp.SUB = 1'b1;
                OP_JMP: begin
                    dp.JMP = 1'b1; dp.flag_label_PC = 1'b1;
                end
                OP_JAL: begin
                    dp.JMP = 1'b1; dp.flag_label_PC = 1'b1;
                    dp.flag_PC_RF = 1'b1; dp.RF_write_en = 1'b1;
                end
                OP_JR: begin
                    dp.JMP = 1'b1; dp.flag_Rd_PC = 1'b1;
                end
                OP_BCOND: begin
                    dp.BRANCH        = take;
                    dp.flag_label_PC = take;
                end
                OP_OUT: dp.flag_OutR = 1'b1;
                OP_HLT: ;
                default: begin
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
                    illegal = 1'b1;
`else
                    illegal = 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_risc_control_unit.sv
// Directed vector bench for risc_control_unit (decode table plus run-control sequences).
module tb_risc_control_unit;
    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic       test_normal, flag_HLT, clr, halted;
    logic [3:0] nzcv;
    int         checks = 0;
    int         errors = 0;

    risc_control_unit_if dp ();

    risc_control_unit dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .dp          (dp),
        .test_normal (test_normal),
        .flag_HLT    (flag_HLT),
        .clr         (clr),
        .nzcv        (nzcv),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] C_SRB  = 19'h1 << 18;
    localparam logic [18:0] C_SALU = 19'h1 << 17;
    localparam logic [18:0] C_ADC  = 19'h1 << 16;
    localparam logic [18:0] C_SUB  = 19'h1 << 15;
    localparam logic [18:0] C_SBB  = 19'h1 << 14;
    localparam logic [18:0] C_JMP  = 19'h1 << 13;
    localparam logic [18:0] C_BR   = 19'h1 << 12;
    localparam logic [18:0] C_LPC  = 19'h1 << 11;
    localparam logic [18:0] C_RDPC = 19'h1 << 9;
    localparam logic [18:0] C_DWE  = 19'h1 << 8;
    localparam logic [18:0] C_MRF  = 19'h1 << 7;
    localparam logic [18:0] C_ARF  = 19'h1 << 6;
    localparam logic [18:0] C_PCRF = 19'h1 << 4;
    localparam logic [18:0] C_RFWE = 19'h1 << 3;
    localparam logic [18:0] C_LHI  = 19'h1 << 2;
    localparam logic [18:0] C_LLI  = 19'h1 << 1;
    localparam logic [18:0] C_OUTR = 19'h1;

`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic [18:0] ctrl;
    assign ctrl = {dp.Src_Read_B, dp.Src_ALU_B, dp.ADC, dp.SUB, dp.SBB, dp.JMP, dp.BRANCH,
                   dp.flag_label_PC, dp.flag_Rm_PC, dp.flag_Rd_PC, dp.data_write_en,
                   dp.flag_mem_RF, dp.flag_ALU_RF, dp.flag_Rm_RF, dp.flag_PC_RF,
                   dp.RF_write_en, dp.LHI, dp.LLI, dp.flag_OutR};

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  pre;      // {N,Z,C,V}
        logic [18:0] ctrl;
        logic [3:0]  nzcv;     // expected after the edge
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] instr, input logic [3:0] pre);
        dp.mem_instr_out = instr;
        {dp.Pre_N, dp.Pre_Z, dp.Pre_C, dp.Pre_V} = pre;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h4227, 4'b1000, C_SUB | C_SALU | C_ARF | C_RFWE, 4'b1000};
        vecs[1]  = '{16'h0000, 4'b0011, C_ARF | C_RFWE,                  4'b0011};
        vecs[2]  = '{16'h0001, 4'b0000, C_ADC | C_ARF | C_RFWE,          4'b0000};
        vecs[3]  = '{16'h0800, 4'b1111, C_LHI | C_SRB | C_RFWE,          4'b0000};
        vecs[4]  = '{16'h4800, 4'b0100, C_SUB,                           4'b0100};
        vecs[5]  = '{16'hC000, 4'b1011, C_BR | C_LPC,                    4'b0100};
        vecs[6]  = '{16'hC100, 4'b1111, 19'h0,                           4'b0100};
        vecs[7]  = '{16'h0003, 4'b1010, C_SBB | C_ARF | C_RFWE,          4'b1010};
        vecs[8]  = '{16'hC200, 4'b1111, C_BR | C_LPC,                    4'b1010};
        vecs[9]  = '{16'hC300, 4'b1111, 19'h0,                           4'b1010};
        vecs[10] = '{16'hC400, 4'b1111, C_BR | C_LPC,                    4'b1010};
        vecs[11] = '{16'hC500, 4'b1111, 19'h0,                           4'b1010};
        vecs[12] = '{16'hC600, 4'b1111, 19'h0,                           4'b1010};
        vecs[13] = '{16'hC700, 4'b1111, C_BR | C_LPC,                    4'b1010};
        vecs[14] = '{16'h0002, 4'b0001, C_SUB | C_ARF | C_RFWE,          4'b0001};
        vecs[15] = '{16'hC600, 4'b1111, C_BR | C_LPC,                    4'b0001};
        vecs[16] = '{16'h1000, 4'b1111, C_LLI | C_RFWE,                  4'b0001};
        vecs[17] = '{16'h1800, 4'b1111, C_SALU | C_MRF | C_RFWE,         4'b0001};
        vecs[18] = '{16'h2000, 4'b1111, C_MRF | C_RFWE,                  4'b0001};
        vecs[19] = '{16'h2800, 4'b1111, C_SALU | C_SRB | C_DWE,          4'b0001};
        vecs[20] = '{16'h3000, 4'b1111, C_SRB | C_DWE,                   4'b0001};
        vecs[21] = '{16'h3800, 4'b0110, C_SALU | C_ARF | C_RFWE,         4'b0110};
        vecs[22] = '{16'h8000, 4'b1111, C_JMP | C_LPC,                   4'b0110};
        vecs[23] = '{16'h8800, 4'b1111, C_JMP | C_LPC | C_PCRF | C_RFWE, 4'b0110};
        vecs[24] = '{16'h9000, 4'b1111, C_JMP | C_RDPC,                  4'b0110};
        vecs[25] = '{16'hE000, 4'b1111, C_OUTR,                          4'b0110};
        vecs[26] = '{16'hC000, 4'b1111, C_BR | C_LPC,                    4'b0110};

        clr_n = 1'b0;
        start = 1'b0;
        drive(16'h0000, 4'b1111);
        #3;
        check("rst_test_normal", 32'(test_normal), 32'd1);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_nzcv", 32'(nzcv), 32'd0);
        check("rst_flag_hlt", 32'(flag_HLT), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        step();
        step();
        check("load_test_normal", 32'(test_normal), 32'd1);
        check("load_clr", 32'(clr), 32'd0);
        check("load_ctrl", 32'(ctrl), 32'd0);
        check("load_nzcv", 32'(nzcv), 32'd0);

        start = 1'b1;
        step();
        check("clear_clr", 32'(clr), 32'd1);
        check("clear_test_normal", 32'(test_normal), 32'd0);
        check("clear_flag_hlt", 32'(flag_HLT), 32'd0);
        check("clear_ctrl", 32'(ctrl), 32'd0);
        step();
        check("run_clr", 32'(clr), 32'd0);
        check("run_flag_hlt", 32'(flag_HLT), 32'd1);
        check("run_test_normal", 32'(test_normal), 32'd0);

        for (int i = 0; i < 27; i++) begin
            if (i == 3) start = 1'b0;
            drive(vecs[i].instr, vecs[i].pre);
            #1;
            check($sformatf("ctrl[%0d]", i), 32'(ctrl), 32'(vecs[i].ctrl));
            step();
            check($sformatf("nzcv[%0d]", i), 32'(nzcv), 32'(vecs[i].nzcv));
            check($sformatf("run[%0d]", i), 32'(flag_HLT), 32'd1);
        end

        drive(16'h7800, 4'b1111);
        #1;
        check("unused_ctrl", 32'(ctrl), 32'd0);
        step();
        check("unused_halted", 32'(halted), 32'(TRAP));
        check("unused_flag_hlt", 32'(flag_HLT), 32'(!TRAP));
        check("unused_nzcv", 32'(nzcv), 32'b0110);
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
        start = 1'b1;
        step();
        check("trap_restart_clr", 32'(clr), 32'd1);
        start = 1'b0;
        step();
        check("trap_restart_run", 32'(flag_HLT), 32'd1);
        check("trap_restart_nzcv", 32'(nzcv), 32'd0);
`endif

        drive(16'hF800, 4'b1111);
        #1;
        check("hlt_ctrl", 32'(ctrl), 32'd0);
        check("hlt_cycle_flag_hlt", 32'(flag_HLT), 32'd1);
        step();
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_flag_hlt", 32'(flag_HLT), 32'd0);
        check("hlt_test_normal", 32'(test_normal), 32'd1);
        drive(16'h0000, 4'b1111);
        #1;
        check("halt_ctrl", 32'(ctrl), 32'd0);
        step();
        check("halt_stays", 32'(halted), 32'd1);

        start = 1'b1;
        step();
        check("restart_clr", 32'(clr), 32'd1);
        check("restart_halted", 32'(halted), 32'd0);
        start = 1'b0;
        step();
        check("restart_clr_done", 32'(clr), 32'd0);
        check("restart_run", 32'(flag_HLT), 32'd1);
        check("restart_nzcv", 32'(nzcv), 32'd0);
        #1;
        check("restart_ctrl", 32'(ctrl), 32'(C_ARF | C_RFWE));
        step();
        check("restart_nzcv_load", 32'(nzcv), 32'b1111);

        #2;
        clr_n = 1'b0;
        #1;
        check("async_test_normal", 32'(test_normal), 32'd1);
        check("async_flag_hlt", 32'(flag_HLT), 32'd0);
        check("async_nzcv", 32'(nzcv), 32'd0);
        check("async_ctrl", 32'(ctrl), 32'd0);
        check("async_halted", 32'(halted), 32'd0);
        check("async_clr", 32'(clr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/risc_control_unit.md
# risc_control_unit

Control unit for the single-cycle RISC datapath. It decodes the 16-bit instruction on `mem_instr_out` each cycle and drives every datapath control input that the datapath bench currently drives by hand. It also owns the NZCV status register, which feeds ADC/SBB and conditional branches. A small run-control FSM (LOAD, CLEAR, RUN, HALT) sequences external memory loading, the datapath clear pulse, execution and halting.

## Interface
- No parameters. Widths are fixed by the ISA: 16-bit instruction, 5-bit opcode.
- `clk` in 1: single clock, rising edge.
- `clr_n` in 1: asynchronous active-low reset.
- `start` in 1: level; leave LOAD or HALT and begin execution.
- `mem_instr_out` in 16: current instruction from instruction memory.
- `Pre_C`, `Pre_V`, `Pre_Z`, `Pre_N` in 1 each: ALU flags for the current cycle.
- `test_normal` out 1: 1 gives external memory ports priority (LOAD/HALT only).
- `flag_HLT` out 1: 1 means the PC advances (RUN only).
- `clr` out 1: one-cycle datapath clear.
- Datapath controls, 1 bit each, all outputs: `Src_Read_B`, `Src_ALU_B`, `ADC`, `SUB`, `SBB`, `JMP`, `BRANCH`, `flag_label_PC`, `flag_Rm_PC`, `flag_Rd_PC`, `data_write_en`, `flag_mem_RF`, `flag_ALU_RF`, `flag_Rm_RF`, `flag_PC_RF`, `RF_write_en`, `LHI`, `LLI`, `flag_OutR`.
- `nzcv` out 4: status register {N,Z,C,V}.
- `halted` out 1: FSM is in HALT.

## Operation
- **Reset (`clr_n` = 0):**
  - State LOAD, `nzcv` = 0.
  - `test_normal` = 1 and every other output = 0.
- **FSM:**
  - LOAD: `start` = 1 → CLEAR.
  - CLEAR: `clr` = 1 for exactly one cycle, then → RUN unconditionally.
  - RUN: a HLT opcode → HALT at the next edge.
  - HALT: `start` = 1 → CLEAR.
- **Outside RUN:** every write enable, PC-select and ALU control is 0, and `flag_OutR` = 0.
- **Decode in RUN** (combinational from `mem_instr_out[15:11]`):
  - 00000 ALU reg: `flag_ALU_RF` and `RF_write_en` set. `[1:0]` selects the operation: 00 ADD, 01 ADC (`ADC` = 1), 10 SUB (`SUB` = 1), 11 SBB (`SBB` = 1).
  - 00001 LHI: `LHI`, `Src_Read_B` and `RF_write_en` set.
  - 00010 LLI: `LLI` and `RF_write_en` set.
  - 00011 LDR imm: `Src_ALU_B`, `flag_mem_RF` and `RF_write_en` set.
  - 00100 LDR reg: `flag_mem_RF` and `RF_write_en` set.
  - 00101 STR imm: `Src_ALU_B`, `Src_Read_B` and `data_write_en` set.
  - 00110 STR reg: `Src_Read_B` and `data_write_en` set.
  - 00111 ADDI: `Src_ALU_B`, `flag_ALU_RF` and `RF_write_en` set.
  - 01000 SUBI: as ADDI, plus `SUB`.
  - 01001 CMP: `SUB` set; no register write.
  - 10000 JMP: `JMP` and `flag_label_PC` set.
  - 10001 JAL: `JMP`, `flag_label_PC`, `flag_PC_RF` and `RF_write_en` set.
  - 10010 JR: `JMP` and `flag_Rd_PC` set.
  - 11000 Bcond: `BRANCH` and `flag_label_PC` set only if the condition holds.
  - 11100 OUT: `flag_OutR` set.
  - 11111 HLT: no controls asserted.
- **Branch conditions**, from `[10:8]`:
  - 000 EQ: Z. 001 NE: !Z.
  - 010 CS: C. 011 CC: !C.
  - 100 MI: N. 101 PL: !N.
  - 110 VS: V. 111 AL: always.
- **Status register:** in RUN, on opcodes 00000, 00111, 01000 and 01001, `nzcv` loads {`Pre_N`, `Pre_Z`, `Pre_C`, `Pre_V`} at the clock edge. All other opcodes hold it.
- **Operand sourcing:** ADC/SBB use the registered C, not `Pre_C`. Conditions evaluate the registered `nzcv`.
- **Unused opcodes:** NOP, with all controls 0.

## Timing
- Decode is zero-latency combinational. Controls are valid in the same cycle as `mem_instr_out`.
- `nzcv` updates one edge after the flag-setting instruction, so it is visible to the next instruction.
- HLT: controls are 0 during the HLT cycle. `halted` = 1 and `flag_HLT` = 0 from the next edge.
- `start` held high in LOAD: CLEAR lasts exactly one cycle and RUN begins on the second edge. A `start` still high in RUN is ignored.
- CLEAR clears `nzcv` to 0.
- `clr_n` asserted mid-RUN immediately forces all reset values, asynchronously.

## Configuration
- Macro `RISC_CTRL_ILLEGAL_TRAP_EN`.
- Defined: an unused opcode in RUN is treated as HLT (→ HALT at the next edge), and `halted` is set.
- Undefined: an unused opcode is a NOP and execution continues.

## Structure
- Package `risc_ctrl_pkg` holds:
  - opcode constants, ALU func codes and condition codes;
  - FSM state typedef (LOAD, CLEAR, RUN, HALT);
  - NZCV bit-index constants.
- One combinational sub-module, `risc_cond_eval`: inputs cond[2:0] and nzcv[3:0], output `take`.

## Test plan
- Reset, then release with `start` = 0 → `test_normal` = 1, `flag_HLT` = 0, all controls 0, state stays LOAD.
- `start` = 1 in LOAD → `clr` = 1 for exactly one cycle, then `flag_HLT` = 1 and `test_normal` = 0.
- RUN with instruction 16'b01000_010_001_00111 (SUBI), `Pre_N`/`Pre_Z`/`Pre_C`/`Pre_V` = 1/0/0/0 → `SUB`, `Src_ALU_B`, `flag_ALU_RF` and `RF_write_en` = 1, and `nzcv` = 4'b1000 after the edge.
- After CMP with `Pre_Z` = 1, Bcond with cond 000 → `BRANCH` = 1 and `flag_label_PC` = 1. The same Bcond with cond 001 → both 0.
- HLT (16'hF800) → `halted` = 1 and `flag_HLT` = 0 at the next edge. A following `start` = 1 → CLEAR pulse, then RUN.
- Opcode 01111:
  - with `RISC_CTRL_ILLEGAL_TRAP_EN` defined → HALT at the next edge;
  - without it → all controls 0 and the FSM stays in RUN.
